// File: rtl/fpu_mc_sequencer.sv
// fpu_mc_sequencer: execute-stage sequencer for iterative FPU ops (fdiv, fsqrt).
// Starts the selected unit, stalls IF/ID/EX and bubbles MA while the op runs,
// pulses result_valid on the completion cycle and profiles stalled cycles.
module fpu_mc_sequencer #(
   parameter int DIV_LAT  = 2,
   parameter int SQRT_LAT = 1,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             op_valid_e,
   input  logic [4:0]       fpu_ctrl_e,
   input  logic [5:0]       wreg_e,
   output logic             unit_start,
   output logic [1:0]       unit_sel,
   output logic             stall_fde,
   output logic             flush_m,
   output logic             result_valid,
   output logic [5:0]       result_wreg,
   output logic             busy,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [4:0] FC_FDIV  = 5'b00111;
   localparam logic [4:0] FC_FSQRT = 5'b01101;

   localparam logic [1:0] SEL_NONE = 2'd0;
   localparam logic [1:0] SEL_DIV  = 2'd1;
   localparam logic [1:0] SEL_SQRT = 2'd2;

   // Iteration counter only needs to hold the largest LAT-1 value.
   localparam int MAX_LAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
   localparam int LC_W    = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

   // A unit with zero latency is never loaded, so its load value is irrelevant.
   localparam logic [LC_W-1:0] DIV_LOAD  = (DIV_LAT  > 0) ? LC_W'(DIV_LAT  - 1) : '0;
   localparam logic [LC_W-1:0] SQRT_LOAD = (SQRT_LAT > 0) ? LC_W'(SQRT_LAT - 1) : '0;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t            state_q;
   logic [LC_W-1:0]   cnt_q;
   logic [1:0]        sel_q;
   logic [5:0]        wreg_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic              is_div;
   logic              is_sqrt;
   logic              mc;
   logic [1:0]        sel_op;
   logic [LC_W-1:0]   load_op;
   logic              idle_mc;
   logic              in_busy;

   // Decode the execute instruction into a multi-cycle request and its unit.
   always_comb begin
      is_div  = op_valid_e && (fpu_ctrl_e == FC_FDIV)  && (DIV_LAT  > 0);
      is_sqrt = op_valid_e && (fpu_ctrl_e == FC_FSQRT) && (SQRT_LAT > 0);
      mc      = is_div || is_sqrt;
      sel_op  = SEL_NONE;
      load_op = '0;
      if (is_div) begin
         sel_op  = SEL_DIV;
         load_op = DIV_LOAD;
      end else if (is_sqrt) begin
         sel_op  = SEL_SQRT;
         load_op = SQRT_LOAD;
      end
   end

   // Cycle-0 controls are combinational for the hazard unit; gating with rstn
   // keeps every output low while reset is asserted even if an op is on the bus.
   always_comb begin
      idle_mc      = rstn && (state_q == S_IDLE) && mc;
      in_busy      = (state_q == S_BUSY);
      unit_start   = idle_mc;
      stall_fde    = idle_mc || (in_busy && (cnt_q != '0));
      flush_m      = stall_fde;
      result_valid = in_busy && (cnt_q == '0);
      result_wreg  = in_busy ? wreg_q : 6'd0;
      busy         = in_busy;
      if (in_busy) begin
         unit_sel = sel_q;
      end else if (idle_mc) begin
         unit_sel = sel_op;
      end else begin
         unit_sel = SEL_NONE;
      end
      stall_cycles = stall_cnt_q;
   end

   // Sequencer FSM: accept an op in IDLE, count down its remaining stall cycles
   // in BUSY; the op still sitting in EX on the completion cycle is ignored
   // because the state is BUSY, so it cannot re-trigger.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= SEL_NONE;
         wreg_q  <= 6'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mc) begin
                  state_q <= S_BUSY;
                  cnt_q   <= load_op;
                  sel_q   <= sel_op;
                  wreg_q  <= wreg_e;
               end
            end
            S_BUSY: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - LC_W'(1);
               end else begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Profiling counter of stalled cycles; sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stall_cnt_q <= '0;
      end else if (stall_fde && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_fpu_mc_sequencer.sv
// Bench for fpu_mc_sequencer: per-cycle control checks plus a scoreboard of
// expected completing destinations, and a CNT_W=4 instance for saturation.
module tb_fpu_mc_sequencer;

   localparam logic [4:0] FDIV  = 5'b00111;
   localparam logic [4:0] FSQRT = 5'b01101;
   localparam logic [4:0] FADD  = 5'b00001;

   logic        clk = 1'b0;
   logic        rstn;
   logic        rstn_s;
   logic        op_valid_e;
   logic [4:0]  fpu_ctrl_e;
   logic [5:0]  wreg_e;

   logic        unit_start, stall_fde, flush_m, result_valid, busy;
   logic [1:0]  unit_sel;
   logic [5:0]  result_wreg;
   logic [31:0] stall_cycles;

   logic        unit_start_s, stall_fde_s, flush_m_s, result_valid_s, busy_s;
   logic [1:0]  unit_sel_s;
   logic [5:0]  result_wreg_s;
   logic [3:0]  stall_cycles_s;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          exp_stall = 0;
   logic [5:0]  sb[$];

   always #5 clk = ~clk;

   fpu_mc_sequencer #(.DIV_LAT(2), .SQRT_LAT(1), .CNT_W(32)) dut (
      .clk(clk), .rstn(rstn), .op_valid_e(op_valid_e), .fpu_ctrl_e(fpu_ctrl_e),
      .wreg_e(wreg_e), .unit_start(unit_start), .unit_sel(unit_sel),
      .stall_fde(stall_fde), .flush_m(flush_m), .result_valid(result_valid),
      .result_wreg(result_wreg), .busy(busy), .stall_cycles(stall_cycles)
   );

   fpu_mc_sequencer #(.DIV_LAT(2), .SQRT_LAT(1), .CNT_W(4)) dut_sat (
      .clk(clk), .rstn(rstn_s), .op_valid_e(op_valid_e), .fpu_ctrl_e(fpu_ctrl_e),
      .wreg_e(wreg_e), .unit_start(unit_start_s), .unit_sel(unit_sel_s),
      .stall_fde(stall_fde_s), .flush_m(flush_m_s), .result_valid(result_valid_s),
      .result_wreg(result_wreg_s), .busy(busy_s), .stall_cycles(stall_cycles_s)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard: every completion must match the oldest outstanding op.
   always @(negedge clk) begin
      if (result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_result_valid", 64'd1, 64'd0);
         end else begin
            check("result_wreg", result_wreg, sb.pop_front());
         end
      end
   end

   task automatic run_mc(input logic [4:0] code, input logic [5:0] wreg, input int lat,
                         input logic [1:0] sel);
      sb.push_back(wreg);
      exp_stall += lat;
      for (int k = 0; k <= lat; k++) begin
         @(posedge clk); #1;
         op_valid_e = 1'b1; fpu_ctrl_e = code; wreg_e = wreg;
         @(negedge clk);
         if (k < lat) begin
            check("stall", stall_fde, 1);
            check("flush", flush_m, 1);
            check("start", unit_start, (k == 0) ? 1 : 0);
            check("rv_early", result_valid, 0);
         end else begin
            check("stall_end", stall_fde, 0);
            check("flush_end", flush_m, 0);
            check("start_end", unit_start, 0);
            check("rv", result_valid, 1);
            check("stall_cycles", stall_cycles, exp_stall);
         end
         check("unit_sel", unit_sel, sel);
         check("busy", busy, (k > 0) ? 1 : 0);
      end
   endtask

   task automatic idle_cycle(input logic v, input logic [4:0] code);
      @(posedge clk); #1;
      op_valid_e = v; fpu_ctrl_e = code; wreg_e = 6'd3;
      @(negedge clk);
      check("idle_stall", stall_fde, 0);
      check("idle_start", unit_start, 0);
      check("idle_flush", flush_m, 0);
      check("idle_busy", busy, 0);
      check("idle_sel", unit_sel, 0);
      check("idle_rv", result_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn = 1'b0; rstn_s = 1'b0;
      op_valid_e = 1'b1; fpu_ctrl_e = FDIV; wreg_e = 6'd1;
      repeat (2) @(negedge clk);
      // held in reset with an fdiv on the bus: everything must stay low
      check("rst_start", unit_start, 0);
      check("rst_stall", stall_fde, 0);
      check("rst_flush", flush_m, 0);
      check("rst_sel", unit_sel, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", stall_cycles, 0);
      op_valid_e = 1'b0; fpu_ctrl_e = 5'd0; wreg_e = 6'd0;
      #1 rstn = 1'b1;

      // fdiv, wreg 12
      run_mc(FDIV, 6'd12, 2, 2'd1);
      idle_cycle(1'b0, 5'd0);
      // fsqrt
      run_mc(FSQRT, 6'd33, 1, 2'd2);
      idle_cycle(1'b0, 5'd0);
      // fdiv then fsqrt back to back
      run_mc(FDIV, 6'd5, 2, 2'd1);
      run_mc(FSQRT, 6'd7, 1, 2'd2);
      // single-cycle op and a bubble carrying the fdiv code
      idle_cycle(1'b1, FADD);
      idle_cycle(1'b1, FADD);
      idle_cycle(1'b0, FDIV);
      idle_cycle(1'b0, FDIV);

      // asynchronous reset in cycle 1 of an fdiv
      @(posedge clk); #1;
      op_valid_e = 1'b1; fpu_ctrl_e = FDIV; wreg_e = 6'd20;
      @(negedge clk);
      check("abort_start", unit_start, 1);
      @(posedge clk); #3;
      rstn = 1'b0;
      #1;
      check("abort_stall", stall_fde, 0);
      check("abort_flush", flush_m, 0);
      check("abort_busy", busy, 0);
      check("abort_sel", unit_sel, 0);
      check("abort_rv", result_valid, 0);
      check("abort_wreg", result_wreg, 0);
      check("abort_cnt", stall_cycles, 0);
      exp_stall = 0;
      repeat (2) @(posedge clk);
      #1 op_valid_e = 1'b0; fpu_ctrl_e = 5'd0; wreg_e = 6'd0;
      @(negedge clk); #1 rstn = 1'b1;
      run_mc(FDIV, 6'd12, 2, 2'd1);
      idle_cycle(1'b0, 5'd0);

      // saturation on the 4-bit counter instance
      @(negedge clk); #1 rstn_s = 1'b1;
      check("sat_start", stall_cycles_s, 0);
      for (int i = 1; i <= 9; i++) begin
         run_mc(FDIV, 6'(i), 2, 2'd1);
         check("sat_cnt", stall_cycles_s, (2 * i > 15) ? 15 : 2 * i);
      end
      idle_cycle(1'b0, 5'd0);
      check("sat_hold", stall_cycles_s, 15);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fpu_mc_sequencer.md
# fpu_mc_sequencer

Sequences multi-cycle FPU operations (fdiv, fsqrt) in the execute stage of the 2nd-arch pipeline. It starts the selected iterative unit, holds the front of the pipeline with a stall while the op runs, and injects a bubble into MA. It flags the completion cycle and keeps a saturating stall-cycle counter for profiling. It replaces free-running counter-based float-stall logic with an explicit FSM that cannot re-trigger on the op it is already serving.

## Interface

Parameters:
- DIV_LAT, 2: extra execute cycles for fdiv (stall cycles); 0 means treat as single-cycle.
- SQRT_LAT, 1: extra execute cycles for fsqrt; 0 means single-cycle.
- CNT_W, 32: width of the stall-cycle profiling counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- op_valid_e  in  1  execute stage holds a valid (non-bubble) instruction.
- fpu_ctrl_e  in  5  FPU control code of the execute instruction. fdiv=5'b00111, fsqrt=5'b01101; all other codes are single-cycle.
- wreg_e  in  6  destination register of the execute instruction.
- unit_start  out  1  one-cycle start pulse to the selected iterative unit.
- unit_sel  out  2  0 none, 1 fdiv, 2 fsqrt; held for the whole operation.
- stall_fde  out  1  stall IF, ID and EX pipeline registers.
- flush_m  out  1  insert a bubble into the EX/MA register.
- result_valid  out  1  pulse: unit result is valid this cycle; EX/MA latches it.
- result_wreg  out  6  destination of the completing op; valid with result_valid.
- busy  out  1  FSM not IDLE.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_fde=1.

## Operation

- States: IDLE, BUSY.
- Multi-cycle op (mc) = op_valid_e, with fpu_ctrl_e being fdiv and DIV_LAT>0, or fsqrt and SQRT_LAT>0.
- IDLE, no mc:
  - All outputs low except stall_cycles; unit_sel=0.
- IDLE, mc:
  - unit_start=1 and stall_fde=1 combinationally in the same cycle.
  - flush_m=1, unit_sel driven from the op code.
  - Latch sel, cnt=LAT-1 and wreg_e.
  - Next state BUSY.
- BUSY, cnt!=0:
  - stall_fde=1, flush_m=1, cnt decrements.
  - Inputs are ignored; the same instruction remains in EX.
- BUSY, cnt==0:
  - stall_fde=0, flush_m=0, result_valid=1, result_wreg = latched wreg.
  - Next state IDLE.
  - The op still visible on fpu_ctrl_e this cycle does not re-start, because the state is BUSY.
- Total stall cycles per op = LAT; the op occupies EX for LAT+1 cycles.
- unit_sel and result_wreg hold their latched values throughout BUSY.
- Single-cycle codes, op_valid_e=0, or LAT=0: no stall, no start, no state change.
- stall_cycles:
  - Increments by 1 in every cycle where stall_fde=1.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.

## Timing

- Reset (rstn=0, asynchronous) forces:
  - State IDLE, cnt=0, latched sel=0, latched wreg=0, stall_cycles=0.
  - All outputs 0: unit_start, unit_sel, stall_fde, flush_m, result_valid, result_wreg, busy, stall_cycles.
- Reset mid-operation aborts the op immediately.
  - No result_valid is issued for the aborted op.
  - The first cycle after release is IDLE and accepts a new mc normally.
- Latency from mc appearing in EX (cycle 0) to result_valid: LAT cycles. result_valid is asserted in cycle LAT.
- stall_fde, unit_start and flush_m in cycle 0 are combinational from inputs (same-cycle), as the hazard unit requires.
- busy is registered: it rises in cycle 1 and falls in the cycle after result_valid.
- Back-to-back mc ops: the next op enters EX in cycle LAT+1 (state IDLE) and is accepted there, with no dead cycle.
- The counter carries no wrap risk: cnt width = clog2(max(DIV_LAT,SQRT_LAT)+1). Each LAT is loaded minus 1 only when LAT>0.

## Test plan

- Reset then fdiv (DIV_LAT=2), wreg_e=6'd12, held while stalled:
  - Cycles 0,1: stall_fde=1.
  - Cycle 0: unit_start=1, unit_sel=1.
  - Cycle 2: stall_fde=0, result_valid=1, result_wreg=12.
  - stall_cycles=2.
- fsqrt (SQRT_LAT=1):
  - Stall in cycle 0 only, unit_sel=2.
  - result_valid in cycle 1.
  - Exactly one unit_start pulse.
- fdiv immediately followed by fsqrt:
  - Second unit_start in cycle 3.
  - result_valid in cycles 2 and 4.
  - stall_cycles=3.
- fadd (5'b00001) and a bubble carrying fdiv code (op_valid_e=0): no stall, no start, busy=0.
- rstn low asynchronously in cycle 1 of fdiv:
  - Outputs 0 without waiting for a clock edge.
  - No result_valid.
  - A new fdiv after release behaves as in scenario 1.
- CNT_W=4 with 8 consecutive fdiv ops (16 stall cycles): stall_cycles saturates at 15 and holds.
